// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-stage register-file write arbiter.
// Decodes the MEM/WB instruction into a pipeline write, buffers out-of-order
// mult/div results in a DEPTH-entry FIFO retired on idle pipeline cycles, and
// tracks per-register pending mult/div results for the hazard unit.
// Optional feature macro: WB_EXCEPTION_EN (redirects faulting results to $30
// with the zero-extended exception code as data).
module wb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mw_IR,
   input  logic [31:0] mw_O,
   input  logic [31:0] mw_D,
   input  logic [2:0]  mw_exc,
   input  logic        md_issue,
   input  logic [4:0]  md_issue_rd,
   input  logic        md_valid,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_result,
   input  logic [2:0]  md_exc,
   output logic        md_ready,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic [31:0] pending
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;
   localparam logic [4:0] REG_EXC  = 5'd30;

   // FIFO storage: original rd (for scoreboard clear), write destination, data
   logic [4:0]    fifo_rd_r   [DEPTH];
   logic [4:0]    fifo_dest_r [DEPTH];
   logic [31:0]   fifo_data_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [31:0]   pending_r;

   logic [4:0]  opcode_s;
   logic [4:0]  rd_s;
   logic [4:0]  aluop_s;
   logic [4:0]  pipe_dest_s;
   logic [31:0] pipe_raw_data_s;
   logic        pipe_we_s;
   logic [4:0]  pipe_wdest_s;
   logic [31:0] pipe_wdata_s;
   logic [4:0]  md_dest_s;
   logic [31:0] md_data_s;
   logic        md_ready_s;
   logic        md_accept_s;
   logic        fifo_empty_s;
   logic        pop_s;
   logic        push_s;
   logic        direct_s;
   logic        retire_s;
   logic [4:0]  retire_rd_s;
   logic [31:0] set_mask_s;
   logic [31:0] clr_mask_s;
   logic [31:0] pending_nxt_s;

   assign opcode_s = mw_IR[31:27];
   assign rd_s     = mw_IR[26:22];
   assign aluop_s  = mw_IR[6:2];

   // Decode the MEM/WB instruction into a raw destination and result source
   always_comb begin
      pipe_dest_s     = 5'd0;
      pipe_raw_data_s = mw_O;
      case (opcode_s)
         OP_RTYPE: begin
            if ((aluop_s != ALU_MUL) && (aluop_s != ALU_DIV)) begin
               pipe_dest_s = rd_s;
            end else begin
               pipe_dest_s = 5'd0;
            end
         end
         OP_ADDI: pipe_dest_s = rd_s;
         OP_LW: begin
            pipe_dest_s     = rd_s;
            pipe_raw_data_s = mw_D;
         end
         OP_JAL:  pipe_dest_s = 5'd31;
         OP_SETX: pipe_dest_s = 5'd30;
         default: pipe_dest_s = 5'd0;
      endcase
   end

   // Writes to $0 never happen, so a zero destination doubles as "no write"
   assign pipe_we_s = (pipe_dest_s != 5'd0);

`ifdef WB_EXCEPTION_EN
   assign pipe_wdest_s = (mw_exc != 3'd0) ? REG_EXC : pipe_dest_s;
   assign pipe_wdata_s = (mw_exc != 3'd0) ? {29'd0, mw_exc} : pipe_raw_data_s;
   assign md_dest_s    = (md_exc != 3'd0) ? REG_EXC : md_rd;
   assign md_data_s    = (md_exc != 3'd0) ? {29'd0, md_exc} : md_result;
`else
   logic unused_exc_s;
   assign unused_exc_s = ^{mw_exc, md_exc};
   assign pipe_wdest_s = pipe_dest_s;
   assign pipe_wdata_s = pipe_raw_data_s;
   assign md_dest_s    = md_rd;
   assign md_data_s    = md_result;
`endif

   // Results for $0 and results arriving while full are discarded outright
   assign md_ready_s   = (count_r < DEPTH_C);
   assign md_accept_s  = md_valid && (md_rd != 5'd0) && md_ready_s;
   assign fifo_empty_s = (count_r == {CW{1'b0}});
   assign pop_s        = !pipe_we_s && !fifo_empty_s;
   assign direct_s     = md_accept_s && !pipe_we_s && fifo_empty_s;
   assign push_s       = md_accept_s && (pipe_we_s || !fifo_empty_s);
   assign retire_s     = pop_s || direct_s;
   assign retire_rd_s  = pop_s ? fifo_rd_r[rd_ptr_r] : md_rd;

   // Register-file port mux: pipeline, then FIFO head, then direct md result
   always_comb begin
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = 5'd0;
      data_writeReg    = 32'd0;
      if (reset) begin
         ctrl_writeEnable = 1'b0;
      end else if (pipe_we_s) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg    = pipe_wdest_s;
         data_writeReg    = pipe_wdata_s;
      end else if (pop_s) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg    = fifo_dest_r[rd_ptr_r];
         data_writeReg    = fifo_data_r[rd_ptr_r];
      end else if (direct_s) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg    = md_dest_s;
         data_writeReg    = md_data_s;
      end else begin
         ctrl_writeEnable = 1'b0;
      end
   end

   // Scoreboard next state: issue sets, retirement clears, set wins on a tie
   always_comb begin
      set_mask_s = 32'd0;
      clr_mask_s = 32'd0;
      if (md_issue) begin
         set_mask_s[md_issue_rd] = 1'b1;
      end else begin
         set_mask_s = 32'd0;
      end
      if (retire_s) begin
         clr_mask_s[retire_rd_s] = 1'b1;
      end else begin
         clr_mask_s = 32'd0;
      end
      pending_nxt_s    = (pending_r & ~clr_mask_s) | set_mask_s;
      pending_nxt_s[0] = 1'b0;
   end

   // FIFO pointers, occupancy and scoreboard state
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {CW{1'b0}};
         pending_r <= 32'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         pending_r <= pending_nxt_s;
      end
   end

   // FIFO payload storage (datapath only, not reset)
   always_ff @(posedge clk) begin
      if (!reset && push_s) begin
         fifo_rd_r[wr_ptr_r]   <= md_rd;
         fifo_dest_r[wr_ptr_r] <= md_dest_s;
         fifo_data_r[wr_ptr_r] <= md_data_s;
      end
   end

   assign md_ready = md_ready_s;
   assign pending  = pending_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: expected register-file writes are queued
// when stimulus is driven and compared against the combinational write port.
module tb_wb_arbiter;

   localparam logic [31:0] ADDI5 = 32'h29400003;
   localparam logic [31:0] LW6   = 32'h41800000;
   localparam logic [31:0] JAL   = 32'h18000000;
   localparam logic [31:0] SETX  = 32'hA8000000;
   localparam logic [31:0] MUL7  = 32'h01C00018;
   localparam logic [31:0] DIV7  = 32'h01C0001C;
   localparam logic [31:0] ADD7  = 32'h01C00000;
   localparam logic [31:0] ADDI0 = 32'h28000000;
   localparam logic [31:0] SW5   = 32'h39400000;

   typedef struct {
      logic        we;
      logic [4:0]  rg;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mw_IR, mw_O, mw_D;
   logic [2:0]  mw_exc;
   logic        md_issue;
   logic [4:0]  md_issue_rd;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_result;
   logic [2:0]  md_exc;
   logic        md_ready;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [31:0] pending;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   step   = 0;

   wb_arbiter #(.DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .mw_IR(mw_IR), .mw_O(mw_O), .mw_D(mw_D), .mw_exc(mw_exc),
      .md_issue(md_issue), .md_issue_rd(md_issue_rd),
      .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result), .md_exc(md_exc),
      .md_ready(md_ready),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s step %0d: observed %h expected %h", tag, step, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      mw_IR = 32'd0; mw_O = 32'd0; mw_D = 32'd0; mw_exc = 3'd0;
      md_issue = 1'b0; md_issue_rd = 5'd0;
      md_valid = 1'b0; md_rd = 5'd0; md_result = 32'd0; md_exc = 3'd0;
   endtask

   // One cycle: queue the expected write, compare mid-cycle, advance a clock
   task automatic cyc(input logic we, input logic [4:0] rg, input logic [31:0] dat);
      exp_t e;
      exp_t got;
      e.we = we; e.rg = rg; e.data = dat;
      sb.push_back(e);
      step++;
      #1;
      got = sb.pop_front();
      chk("we",   {31'd0, ctrl_writeEnable}, {31'd0, got.we});
      chk("reg",  {27'd0, ctrl_writeReg},    {27'd0, got.rg});
      chk("data", data_writeReg,             got.data);
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      // write port is silent during reset even with a valid instruction
      reset = 1'b1; mw_IR = ADDI5; mw_O = 32'd7;
      cyc(1'b0, 5'd0, 32'd0);
      reset = 1'b0;
      chk("rst_pending", pending, 32'd0);
      chk("rst_ready", {31'd0, md_ready}, 32'd1);

      // basic pipeline writes
      mw_IR = ADDI5; mw_O = 32'd7;        cyc(1'b1, 5'd5, 32'd7);
      mw_IR = LW6;   mw_D = 32'hDEADBEEF; cyc(1'b1, 5'd6, 32'hDEADBEEF);

      // nop and md result to $0 write nothing, nothing queued
      cyc(1'b0, 5'd0, 32'd0);
      md_valid = 1'b1; md_rd = 5'd0; md_result = 32'd99; cyc(1'b0, 5'd0, 32'd0);
      chk("zero_ready", {31'd0, md_ready}, 32'd1);
      cyc(1'b0, 5'd0, 32'd0);

      // issue then direct same-cycle retirement
      md_issue = 1'b1; md_issue_rd = 5'd9; cyc(1'b0, 5'd0, 32'd0);
      chk("pend9_set", pending, 32'h0000_0200);
      cyc(1'b0, 5'd0, 32'd0);
      cyc(1'b0, 5'd0, 32'd0);
      md_valid = 1'b1; md_rd = 5'd9; md_result = 32'd42; cyc(1'b1, 5'd9, 32'd42);
      chk("pend9_clr", pending, 32'd0);

      // md result collides with pipeline write, retired next idle cycle
      md_issue = 1'b1; md_issue_rd = 5'd10; cyc(1'b0, 5'd0, 32'd0);
      mw_IR = ADDI5; mw_O = 32'd1;
      md_valid = 1'b1; md_rd = 5'd10; md_result = 32'd5; cyc(1'b1, 5'd5, 32'd1);
      chk("pend10_q", pending, 32'h0000_0400);
      chk("ready_q1", {31'd0, md_ready}, 32'd1);
      cyc(1'b1, 5'd10, 32'd5);
      chk("pend10_clr", pending, 32'd0);

      // fill the FIFO, drop one while full, drain in order
      md_issue = 1'b1; md_issue_rd = 5'd11; cyc(1'b0, 5'd0, 32'd0);
      md_issue = 1'b1; md_issue_rd = 5'd12; cyc(1'b0, 5'd0, 32'd0);
      mw_IR = ADDI5; mw_O = 32'd2;
      md_valid = 1'b1; md_rd = 5'd11; md_result = 32'h111; cyc(1'b1, 5'd5, 32'd2);
      mw_IR = LW6; mw_D = 32'd3;
      md_valid = 1'b1; md_rd = 5'd12; md_result = 32'h222; cyc(1'b1, 5'd6, 32'd3);
      chk("full_ready", {31'd0, md_ready}, 32'd0);
      chk("full_pend", pending, 32'h0000_1800);
      mw_IR = ADDI5; mw_O = 32'd4;
      md_valid = 1'b1; md_rd = 5'd13; md_result = 32'h333; cyc(1'b1, 5'd5, 32'd4);
      chk("drop_ready", {31'd0, md_ready}, 32'd0);
      cyc(1'b1, 5'd11, 32'h111);
      chk("pop1_ready", {31'd0, md_ready}, 32'd1);
      cyc(1'b1, 5'd12, 32'h222);
      cyc(1'b0, 5'd0, 32'd0);
      chk("drain_pend", pending, 32'd0);

      // decode coverage
      mw_IR = JAL;   mw_O = 32'h55; cyc(1'b1, 5'd31, 32'h55);
      mw_IR = SETX;  mw_O = 32'h66; cyc(1'b1, 5'd30, 32'h66);
      mw_IR = MUL7;  mw_O = 32'd1;  cyc(1'b0, 5'd0, 32'd0);
      mw_IR = DIV7;  mw_O = 32'd1;  cyc(1'b0, 5'd0, 32'd0);
      mw_IR = ADD7;  mw_O = 32'd9;  cyc(1'b1, 5'd7, 32'd9);
      mw_IR = ADDI0; mw_O = 32'd1;  cyc(1'b0, 5'd0, 32'd0);
      mw_IR = SW5;   mw_O = 32'd1;  cyc(1'b0, 5'd0, 32'd0);

      // simultaneous pop and push keeps count
      mw_IR = ADDI5; mw_O = 32'd0;
      md_valid = 1'b1; md_rd = 5'd14; md_result = 32'h14; cyc(1'b1, 5'd5, 32'd0);
      md_valid = 1'b1; md_rd = 5'd15; md_result = 32'h15; cyc(1'b1, 5'd14, 32'h14);
      chk("pp_ready", {31'd0, md_ready}, 32'd1);
      cyc(1'b1, 5'd15, 32'h15);
      cyc(1'b0, 5'd0, 32'd0);

      // issue and retire on the same register: set wins
      md_issue = 1'b1; md_issue_rd = 5'd16;
      md_valid = 1'b1; md_rd = 5'd16; md_result = 32'h16; cyc(1'b1, 5'd16, 32'h16);
      chk("setwins", pending, 32'h0001_0000);
      md_valid = 1'b1; md_rd = 5'd16; md_result = 32'h17; cyc(1'b1, 5'd16, 32'h17);
      chk("setwins_clr", pending, 32'd0);

      // reset discards a queued result
      md_issue = 1'b1; md_issue_rd = 5'd17; cyc(1'b0, 5'd0, 32'd0);
      mw_IR = ADDI5; mw_O = 32'd8;
      md_valid = 1'b1; md_rd = 5'd17; md_result = 32'h17; cyc(1'b1, 5'd5, 32'd8);
      chk("prerst_pend", pending, 32'h0002_0000);
      reset = 1'b1; cyc(1'b0, 5'd0, 32'd0);
      reset = 1'b0;
      chk("midrst_pend", pending, 32'd0);
      chk("midrst_ready", {31'd0, md_ready}, 32'd1);
      cyc(1'b0, 5'd0, 32'd0);
      cyc(1'b0, 5'd0, 32'd0);

`ifdef WB_EXCEPTION_EN
      mw_IR = ADDI5; mw_O = 32'd7; mw_exc = 3'd2; cyc(1'b1, 5'd30, 32'd2);
      md_issue = 1'b1; md_issue_rd = 5'd7; cyc(1'b0, 5'd0, 32'd0);
      md_valid = 1'b1; md_rd = 5'd7; md_result = 32'd100; md_exc = 3'd5;
      cyc(1'b1, 5'd30, 32'd5);
      chk("exc_pend", pending, 32'd0);
      mw_IR = ADDI5; mw_O = 32'd1;
      md_valid = 1'b1; md_rd = 5'd8; md_result = 32'd200; md_exc = 3'd3;
      cyc(1'b1, 5'd5, 32'd1);
      cyc(1'b1, 5'd30, 32'd3);
`else
      mw_IR = ADDI5; mw_O = 32'd7; mw_exc = 3'd2; cyc(1'b1, 5'd5, 32'd7);
      md_valid = 1'b1; md_rd = 5'd7; md_result = 32'd100; md_exc = 3'd5;
      cyc(1'b1, 5'd7, 32'd100);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side consumer of the MEM/WB pipeline register. Decodes the latched instruction, selects the result (ALU output or load data), and drives the single register-file write port.
- Also accepts out-of-order results from the multicycle mult/div unit. These are buffered in a small FIFO and retired on cycles when the pipeline is not writing.
- Keeps a per-register pending scoreboard so the hazard unit can stall dependent instructions.

Parameters:
- DEPTH, 2: mult/div result FIFO entries (power of two, >=2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mw_IR  in  32  instruction from MEM/WB register.
- mw_O  in  32  ALU/PC+1/setx-target result from MEM/WB.
- mw_D  in  32  load data from MEM/WB.
- mw_exc  in  3  pipeline exception code (0 = none).
- md_issue  in  1  mult/div operation issued this cycle.
- md_issue_rd  in  5  destination of issued op.
- md_valid  in  1  mult/div result available (1-cycle pulse).
- md_rd  in  5  result destination.
- md_result  in  32  result value.
- md_exc  in  3  mult/div exception code (0 = none).
- md_ready  out  1  FIFO can accept a result (count < DEPTH).
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  regfile write address.
- data_writeReg  out  32  regfile write data.
- pending  out  32  bit r set while a mult/div result for $r is outstanding.

Behaviour:
- Opcode = IR[31:27], rd = IR[26:22], aluop = IR[6:2].
- Pipeline write decode:
  - R-type 00000, except aluop 00110/00111: rd <- mw_O.
  - addi 00101: rd <- mw_O.
  - lw 01000: rd <- mw_D.
  - jal 00011: $31 <- mw_O.
  - setx 10101: $30 <- mw_O.
  - All other opcodes: no write.
- Any write whose destination is $0 is suppressed (pipe_we=0). The nop IR=0 therefore writes nothing.
- Port outputs are combinational, so the regfile latches the write on the same rising edge. Priority order:
  1. pipe_we: pipeline write.
  2. FIFO non-empty: head entry written and popped at the clock edge.
  3. md_valid with the FIFO empty: direct write, no enqueue.
  4. Otherwise ctrl_writeEnable=0, and ctrl_writeReg/data_writeReg are 0.
- md_valid is pushed to the FIFO when it is not written directly, i.e. when pipe_we=1 or the FIFO is non-empty.
- Simultaneous pop and push is legal and the count is unchanged. md_valid with rd=0 is dropped, neither enqueued nor written.
- The FIFO uses circular read/write pointers with a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- md_ready = (count < DEPTH). md_valid while !md_ready is a protocol violation; the result is dropped and state is unchanged.
- Scoreboard:
  - md_issue sets pending[md_issue_rd].
  - An md result is retired when it is written to the regfile, either directly or by FIFO pop. Retiring clears pending[rd].
  - If issue and retire hit the same register in one cycle, set wins.
  - pending[0] is always 0.
- Pipeline writes to a register with pending=1 are guaranteed absent by the hazard unit. The block takes no action on them.
- On reset: FIFO empty, pointers 0, pending=0, md_ready=1, write outputs 0 during the reset cycle.
- Reset mid-operation discards queued results.

Optional Feature:
- Macro WB_EXCEPTION_EN.
- With the macro defined:
  - A pipeline write with mw_exc!=0 is redirected to $30 with data_writeReg = zero-extended mw_exc. The normal rd write does not occur.
  - A mult/div result with md_exc!=0 enqueues or writes $30 with the zero-extended code. pending[md_rd] is still cleared at retirement.
- Without the macro, mw_exc/md_exc are ignored and results go to their normal destinations.

Test Plan:
- Reset, then mw_IR=addi $5 (0x29400003), mw_O=7 -> we=1, reg=5, data=7. Then lw $6 with mw_D=0xDEADBEEF -> reg=6, data=0xDEADBEEF.
- Write to $0: mw_IR=0 (nop), then md_valid with md_rd=0 -> we=0 both cycles, count stays 0.
- md_issue rd=9, then 3 cycles later md_valid rd=9, result=42 with no pipeline write -> same-cycle write $9=42, pending[9] 1->0.
- md_valid rd=10, result=5 during addi $5 -> $5 written that cycle. Next cycle (nop) -> $10=5 popped, pending[10] cleared.
- Fill FIFO: two md_valid pulses during consecutive pipeline writes -> md_ready=0. Then nops -> drain in FIFO order, md_ready=1 after first pop.
- With WB_EXCEPTION_EN: addi with mw_exc=2 -> we=1, reg=30, data=2. md_exc=5 on rd=7 -> $30=5, pending[7] cleared. Reset with 1 queued entry -> nothing written afterward.
